mem_access_ctrl: RTL and testbench

Multicycle load/store sequencer between the execute stage and the Avalon-style data bus of the MIPS CPU. On a start pulse it captures opcode, base register and the 32-bit extended immediate, forms the effective address, runs a single bus transaction honouring `waitrequest`, and returns load data already lane-selected and sign/zero-extended. Misaligned word accesses are trapped before touching the bus. The CPU control FSM stalls on `busy` and advances on `done`.

---
 rtl/mem_access_ctrl.sv | 123 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between execute and the Avalon-style data bus.
// Captures a request, forms the effective address, runs one bus transfer and extends load data.
module mem_access_ctrl #(
  parameter logic [5:0] OPCODE_LW  = 6'h23,
  parameter logic [5:0] OPCODE_SW  = 6'h2B,
  parameter logic [5:0] OPCODE_LB  = 6'h20,
  parameter logic [5:0] OPCODE_LBU = 6'h24,
  parameter logic [5:0] OPCODE_SB  = 6'h28
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        addr_error,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  input  logic        waitrequest
);

  typedef enum logic [1:0] {IDLE, REQ, FIN, ERR} state_t;

  state_t      state, state_nxt;
  logic [5:0]  op_p1;
  logic [1:0]  lane_p1;
  logic        is_load_p1;

  logic [31:0] ea_p0;
  logic        supported_p0;
  logic        is_word_p0;
  logic        is_load_p0;
  logic        misaligned_p0;
  logic        accept_p0;

  // Pick the addressed byte lane (little-endian) and extend it for byte loads.
  function automatic logic [31:0] load_extend(input logic [5:0]  op,
                                              input logic [1:0]  lane,
                                              input logic [31:0] word);
    logic [31:0]        shifted;
    logic signed [7:0]  sbyte;
    logic signed [31:0] sext;
    shifted = word >> {lane, 3'b000};
    sbyte   = signed'(shifted[7:0]);
    sext    = sbyte;
    if (op == OPCODE_LB)
      return unsigned'(sext);
    else if (op == OPCODE_LBU)
      return {24'h0, shifted[7:0]};
    else
      return word;
  endfunction

  // Request decode, stage 0: combinational view of the incoming request.
  always_comb begin
    ea_p0         = base + offset;
    supported_p0  = (opcode == OPCODE_LW) || (opcode == OPCODE_SW) ||
                    (opcode == OPCODE_LB) || (opcode == OPCODE_LBU) ||
                    (opcode == OPCODE_SB);
    is_word_p0    = (opcode == OPCODE_LW) || (opcode == OPCODE_SW);
    is_load_p0    = (opcode == OPCODE_LW) || (opcode == OPCODE_LB) ||
                    (opcode == OPCODE_LBU);
    misaligned_p0 = is_word_p0 && (ea_p0[1:0] != 2'b00);
    accept_p0     = (state == IDLE) && start && supported_p0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept_p0) state_nxt = misaligned_p0 ? ERR : REQ;
      REQ:  if (!waitrequest) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      ERR:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    done       = (state == FIN) || (state == ERR);
    addr_error = (state == ERR);
    read       = (state == REQ) && is_load_p1;
    write      = (state == REQ) && !is_load_p1;
  end

  // Stage 1: captured request and bus-facing registers; bus fields stay frozen through REQ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_p1      <= '0;
      lane_p1    <= '0;
      is_load_p1 <= 1'b0;
      address    <= '0;
      writedata  <= '0;
      byteenable <= '0;
      load_data  <= '0;
    end else begin
      if (accept_p0 && !misaligned_p0) begin
        op_p1      <= opcode;
        lane_p1    <= ea_p0[1:0];
        is_load_p1 <= is_load_p0;
        address    <= {ea_p0[31:2], 2'b00};
        writedata  <= is_word_p0 ? store_data : {4{store_data[7:0]}};
        byteenable <= is_word_p0 ? 4'b1111 : (4'b0001 << ea_p0[1:0]);
      end
      if ((state == REQ) && !waitrequest && is_load_p1)
        load_data <= load_extend(op_p1, lane_p1, readdata);
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed accesses push expected completions,
// a negedge monitor checks every done pulse against the queue.
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  opcode;
  logic [31:0] base, offset, store_data;
  logic        busy, done, addr_error, read, write;
  logic [31:0] load_data, address, writedata, readdata;
  logic [3:0]  byteenable;
  logic        waitrequest;

  localparam logic [5:0] LW = 6'h23, SW = 6'h2B, LB = 6'h20, LBU = 6'h24, SB = 6'h28;

  mem_access_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .base(base),
    .offset(offset), .store_data(store_data), .busy(busy), .done(done),
    .load_data(load_data), .addr_error(addr_error), .address(address),
    .read(read), .write(write), .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata), .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ld;
    logic        ae;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every completion pulse pops one expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("load_data", load_data, e.ld);
        chk("addr_error", {31'd0, addr_error}, {31'd0, e.ae});
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic access(input logic [5:0] op, input logic [31:0] b, input logic [31:0] off,
                        input logic [31:0] sd, input logic [31:0] rd, input int stalls,
                        input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wd,
                        input logic [31:0] e_ld, input logic e_ae, input bit inject);
    exp_t e;
    bit   ld;
    ld = (op == LW) || (op == LB) || (op == LBU);
    @(negedge clk);
    start = 1'b1; opcode = op; base = b; offset = off; store_data = sd;
    e.ld = e_ld; e.ae = e_ae; e.cyc = cyc + (e_ae ? 1 : 2 + stalls);
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; opcode = 6'h00;
    if (e_ae) begin
      @(negedge clk);
      chk("err_read", {31'd0, read}, 32'd0);
      chk("err_write", {31'd0, write}, 32'd0);
      chk("err_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      chk("err_busy_after", {31'd0, busy}, 32'd0);
      return;
    end
    for (int i = 0; i <= stalls; i++) begin
      waitrequest = (i < stalls);
      readdata    = (i < stalls) ? 32'h5A5A_A5A5 : rd;
      if (inject && i == 1) begin
        start = 1'b1; opcode = SW; base = 32'h9000; offset = 32'h0; store_data = 32'hFFFF_FFFF;
      end
      @(negedge clk);
      chk("read", {31'd0, read}, {31'd0, ld});
      chk("write", {31'd0, write}, {31'd0, !ld});
      chk("address", address, e_addr);
      chk("byteenable", {28'd0, byteenable}, {28'd0, e_be});
      if (!ld) chk("writedata", writedata, e_wd);
      @(posedge clk); #1;
      start = 1'b0;
    end
    waitrequest = 1'b1;
    readdata = 32'h0;
    @(negedge clk);
    chk("fin_strobes", {30'd0, read, write}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; opcode = '0; base = '0; offset = '0; store_data = '0;
    readdata = '0; waitrequest = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_addr_error", {31'd0, addr_error}, 32'd0);
    chk("rst_strobes", {30'd0, read, write}, 32'd0);
    chk("rst_address", address, 32'd0);
    chk("rst_writedata", writedata, 32'd0);
    chk("rst_byteenable", {28'd0, byteenable}, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    reset = 1'b0;

    access(LW,  32'h1000, 32'h4,         32'h0,         32'hDEAD_BEEF, 0, 32'h1004, 4'hF,    32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0);
    access(LB,  32'h2000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 3, 32'h1FFC, 4'b1000, 32'h0,         32'hFFFF_FF80, 1'b0, 1'b0);
    access(LBU, 32'h2000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 3, 32'h1FFC, 4'b1000, 32'h0,         32'h0000_0080, 1'b0, 1'b0);
    access(SB,  32'h3000, 32'h1,         32'h1234_56AB, 32'h0,         0, 32'h3000, 4'b0010, 32'hABAB_ABAB, 32'h0000_0080, 1'b0, 1'b0);
    access(SW,  32'h4000, 32'h2,         32'h1111_2222, 32'h0,         0, 32'h0,    4'h0,    32'h0,         32'h0000_0080, 1'b1, 1'b0);
    access(LB,  32'h100,  32'h1,         32'h0,         32'h0000_7F00, 1, 32'h100,  4'b0010, 32'h0,         32'h0000_007F, 1'b0, 1'b0);
    access(SW,  32'h50,   32'h4,         32'hA5A5_1234, 32'h0,         1, 32'h54,   4'hF,    32'hA5A5_1234, 32'h0000_007F, 1'b0, 1'b0);
    access(LW,  32'h10,   32'h10,        32'h0,         32'h1234_5678, 2, 32'h20,   4'hF,    32'h0,         32'h1234_5678, 1'b0, 1'b1);

    // Unsupported opcode in IDLE is dropped.
    @(negedge clk);
    start = 1'b1; opcode = 6'h00; base = 32'h40; offset = 32'h0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("bad_op_busy", {31'd0, busy}, 32'd0);
    chk("bad_op_read", {31'd0, read}, 32'd0);

    // Reset during a stalled read abandons it immediately.
    @(negedge clk);
    start = 1'b1; opcode = LW; base = 32'h0; offset = 32'h40; waitrequest = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_read", {31'd0, read}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_read", {31'd0, read}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    waitrequest = 1'b0;

    access(LW, 32'h0, 32'h8, 32'h0, 32'hCAFE_F00D, 0, 32'h8, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("pending_expectations", exp_q.size(), 32'd0);
    chk("done_count", done_cnt, 32'd9);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
